// File: rtl/apb_quad_enc_array.sv
// APB peripheral with NUM_CH quadrature encoder channels: synchroniser, prescaled
// glitch filter, x4 decode into loadable up/down counters with sticky flags and irq.
module apb_quad_enc_array #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  output logic              irq
);
  localparam int unsigned RUN_W = $clog2(FILT_LEN);
  localparam int unsigned CH_W  = 4;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

  logic [CH_W-1:0] a_ch;
  logic [1:0]      a_off;
  logic            is_glb;
  logic            addr_err;
  logic            setup;
  logic            wr_en;
  logic [7:0]      prescale;
  logic [7:0]      tcnt;
  logic            tick;
  logic [31:0]     rdata;
  logic            unused;

  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [4:0]        ctrl   [NUM_CH];
  logic [2:0]        status [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;

  assign a_ch     = paddr[7:4];
  assign a_off    = paddr[3:2];
  assign is_glb   = (paddr == 8'hFC);
  assign addr_err = !is_glb && (32'(a_ch) >= NUM_CH);
  assign setup    = psel & ~penable;
  assign wr_en    = psel & penable & pwrite & ~addr_err;
  assign pready   = 1'b1;
  assign irq      = |ch_irq;
  assign unused   = ^{paddr[1:0], pwdata};

  // Free-running sample tick generator, restarted by a PRESCALE write
  assign tick = (tcnt == prescale);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      prescale <= '0;
      tcnt     <= '0;
    end else if (wr_en && is_glb) begin
      prescale <= pwdata[7:0];
      tcnt     <= '0;
    end else begin
      tcnt <= tick ? 8'd0 : tcnt + 8'd1;
    end
  end

  // Maps a Gray state onto a 0..3 position so the step direction is a modulo-4 difference
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       pin, s1, s2, smp, filt, prev, pos_d;
    logic [RUN_W-1:0] run, run_nx;
    logic             sel, wr_cnt, wr_ctl, wr_sts;
    logic             en, fwd, bwd, qerr, inc, dec;
    logic [2:0]       set_bits;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       ctrl_q;
    logic [2:0]       sts_q;

    assign pin    = {enc_a[i], enc_b[i]};
    assign sel    = wr_en && !is_glb && (a_ch == CH_W'(i));
    assign wr_cnt = sel && (a_off == 2'd0);
    assign wr_ctl = sel && (a_off == 2'd1);
    assign wr_sts = sel && (a_off == 2'd2);

    always_comb begin
      run_nx = '0;
      if (s2 == smp) run_nx = (run == RUN_LAST) ? run : RUN_W'(run + RUN_W'(1));
    end

    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        s1   <= '0;
        s2   <= '0;
        smp  <= '0;
        run  <= '0;
        filt <= '0;
        prev <= '0;
      end else begin
        s1   <= pin;
        s2   <= s1;
        prev <= filt;
        if (tick) begin
          smp <= s2;
          run <= run_nx;
          if (run_nx == RUN_LAST) filt <= s2;
        end
      end
    end

    assign pos_d    = gray_pos(filt) - gray_pos(prev);
    assign en       = ctrl_q[0];
    assign fwd      = (pos_d == 2'd1);
    assign bwd      = (pos_d == 2'd3);
    assign qerr     = (pos_d == 2'd2);
    assign inc      = en & (ctrl_q[1] ? bwd : fwd);
    assign dec      = en & (ctrl_q[1] ? fwd : bwd);
    assign set_bits = {en & qerr,
                       dec & ~wr_cnt & (cnt_q == '0),
                       inc & ~wr_cnt & (cnt_q == '1)};

    // A COUNT load overrides a simultaneous step; flag set beats write-1-to-clear
    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        cnt_q  <= '0;
        ctrl_q <= '0;
        sts_q  <= '0;
      end else begin
        if (wr_cnt)   cnt_q <= pwdata[CNT_W-1:0];
        else if (inc) cnt_q <= cnt_q + CNT_W'(1);
        else if (dec) cnt_q <= cnt_q - CNT_W'(1);
        if (wr_ctl) ctrl_q <= pwdata[4:0];
        sts_q <= (wr_sts ? (sts_q & ~pwdata[2:0]) : sts_q) | set_bits;
      end
    end

    assign count[i]  = cnt_q;
    assign ctrl[i]   = ctrl_q;
    assign status[i] = sts_q;
    assign ch_irq[i] = |(sts_q & ctrl_q[4:2]);
  end

  always_comb begin
    rdata = '0;
    if (is_glb) begin
      rdata = 32'(prescale);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (a_ch == CH_W'(i)) begin
          case (a_off)
            2'd0:    rdata = 32'(count[i]);
            2'd1:    rdata = 32'(ctrl[i]);
            2'd2:    rdata = 32'(status[i]);
            default: rdata = '0;
          endcase
        end
      end
    end
  end

  // Read data and error are captured in the setup phase and held through the access phase
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end else begin
      prdata  <= (setup && !addr_err) ? rdata : 32'd0;
      pslverr <= setup && addr_err;
    end
  end
endmodule

// File: doc/apb_quad_enc_array.md
Name: apb_quad_enc_array

Overview:
- Multi-channel APB quadrature-encoder peripheral and the parametrised successor to the dual-channel rotary encoder block.
- Per channel: input synchroniser, prescaled digital glitch filter, x4 quadrature decode into a CNT_W-bit up/down counter.
- Adds loadable counts, per-channel enable and direction invert, sticky overflow/underflow/quadrature-error flags, and a combined interrupt.
- Sits on the cape APB bus alongside the other robotics peripherals.

Parameters:
NUM_CH, 4, number of encoder channels (1..15)
CNT_W, 32, counter width in bits (8..32)
FILT_LEN, 4, consecutive identical samples required before a filtered input changes (2..16)

Ports:
pclk  input  1  APB and core clock
preset  input  1  asynchronous active-high reset
psel  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  APB write strobe
paddr  input  8  APB byte address
pwdata  input  32  APB write data
prdata  output  32  APB read data
pready  output  1  always 1
pslverr  output  1  access error
enc_a  input  NUM_CH  encoder A inputs, bit n = channel n
enc_b  input  NUM_CH  encoder B inputs
irq  output  1  level interrupt, OR of enabled sticky flags

Behaviour:
- Reset: one clock, pclk; reset preset is asynchronous, active-high.
- Reset values: all counts 0, CTRL 0, STATUS 0, PRESCALE 0, synchronisers/filters 0, prdata 0, pslverr 0, irq 0.
- Register map, channel n base = n*0x10:
  - +0x0 COUNT: R; W loads pwdata[CNT_W-1:0].
  - +0x4 CTRL: [0] enable, [1] invert direction, [2] irq_en_ovf, [3] irq_en_unf, [4] irq_en_err.
  - +0x8 STATUS: [0] overflow, [1] underflow, [2] quad_err; write-1-to-clear.
  - +0xC: reserved, reads 0.
- Global register 0xFC PRESCALE[7:0]: sample tick every PRESCALE+1 pclk cycles; free-running tick counter restarts at 0 when PRESCALE is written.
- APB protocol:
  - Zero wait states.
  - Writes take effect on the pclk edge ending the access phase (psel & penable & pwrite).
  - prdata is registered on the setup-phase edge (psel & !penable) and valid for the access phase; otherwise 0.
  - Unused upper bits read 0.
  - pslverr = 1 during the access phase for a channel address with n >= NUM_CH, or for 0xF0-0xF8; such writes are ignored and reads return 0.
- Input path: 2-FF synchroniser per input.
- Filter:
  - On each sample tick, compare the synchronised input with the previous sample.
  - Run counter increments when equal, resets to 0 when different.
  - When the run counter reaches FILT_LEN-1, the filtered output takes the sample value.
- Decode: on a change of the filtered {A,B} versus the previous filtered state:
  - Gray step 00->01->11->10->00 = +1; reverse = -1.
  - Invert swaps the sign.
  - Both bits changed = quad_err set; count unchanged.
- Counter arithmetic: modulo 2^CNT_W.
  - +1 from all-ones -> 0, sets overflow.
  - -1 from 0 -> all-ones, sets underflow.
- Enable = 0: filters keep tracking, previous state keeps updating, count frozen, no flags set.
- Simultaneous events:
  - APB COUNT write and a decode step in the same cycle: write wins, the step is lost, no flag.
  - W1C and flag set in the same cycle: set wins.
- Latency: with PRESCALE = 0 and a clean input edge, count changes exactly 2 + FILT_LEN + 1 pclk cycles after the edge is presented at the pin.
- irq = OR over channels of (STATUS & CTRL[4:2]); combinational from registers; deasserts the cycle after the W1C clears it.
- Reset mid-operation: preset asserted at any time returns all state to reset values immediately; an APB access in flight is discarded.

Test Plan:
- Reset then read 0x00, 0x04, 0x08, 0xFC -> all 0, pslverr 0.
- Enable ch0, PRESCALE 0, FILT_LEN 4, drive 8 forward Gray steps spaced 10 cycles -> COUNT0 = 8. Then 3 reverse steps -> 5. Set invert and repeat 8 forward steps -> 5 - 8 = 0xFFFFFFFD, underflow set.
- Write COUNT1 = 0xFFFFFFFF, enable with irq_en_ovf, one forward step -> COUNT1 = 0, STATUS1 = 0x1, irq = 1. Write STATUS1 = 0x1 -> irq = 0 next cycle.
- 2-cycle glitch on enc_a2 with FILT_LEN 4 -> COUNT2 unchanged, no quad_err. A and B toggled in the same cycle, held 10 cycles -> quad_err set, COUNT2 unchanged.
- COUNT0 write issued in the same cycle as a decoded step -> COUNT0 = written value exactly.
- Read 0x40 with NUM_CH = 4 -> prdata 0, pslverr 1. Assert preset mid-count -> all counts 0, irq 0, immediately.
